// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard/sequencing controller for the 5-stage pipeline.
// Merges fetch, decode and memory stall sources into per-stage hold/bubble
// controls. Owns delay-slot-aware branch redirection and the debug perf counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_busy,
    input  logic             d_busy,
    input  logic             load_use,
    input  logic             branch_taken,
    input  logic [31:0]      branch_target,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_w,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             redir_pending,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_dstall,
    output logic [CNT_W-1:0] cnt_lustall,
    output logic [CNT_W-1:0] cnt_istall,
    output logic [CNT_W-1:0] cnt_branch
);

    localparam int NUM_CNT = 5;

    typedef enum logic {IDLE, PEND} state_t;

    state_t      state, state_nxt;
    logic [31:0] pend_pc;

    logic        hold_d, hold_f, accept;
    logic        rv_raw;
    logic [31:0] rpc_raw;

    // counter index: 0 cycle, 1 dstall, 2 lustall, 3 istall, 4 branch
    logic [NUM_CNT-1:0]            cnt_inc;
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt;

    // Raw stall terms; a memory wait freezes everything behind it.
    assign hold_d = d_busy | load_use;
    assign hold_f = hold_d | i_busy;

    // Redirect FSM: next state, branch acceptance and redirect outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        rv_raw    = 1'b0;
        rpc_raw   = '0;
        case (state)
            IDLE: begin
                // A branch held in D by a stall is re-presented next cycle.
                accept = branch_taken & ~hold_d;
                if (accept && !i_busy) begin
                    rv_raw  = 1'b1;
                    rpc_raw = branch_target;
                end else if (accept) begin
                    // Delay-slot fetch still outstanding: park the target.
                    state_nxt = PEND;
                end
            end
            PEND: begin
                // branch_taken is ignored here; D only carries bubbles.
                rv_raw  = 1'b1;
                rpc_raw = pend_pc;
                if (!hold_f) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register and parked redirect target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pend_pc <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && accept && i_busy) pend_pc <= branch_target;
        end
    end

    // One stall counter per stalled cycle, d_busy > load_use > i_busy.
    assign cnt_inc[0] = 1'b1;
    assign cnt_inc[1] = d_busy;
    assign cnt_inc[2] = ~d_busy & load_use;
    assign cnt_inc[3] = ~d_busy & ~load_use & i_busy;
    assign cnt_inc[4] = accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            // Free-running wrap-around perf counter.
            always_ff @(posedge clk) begin
                if (reset)           cnt[gi] <= '0;
                else if (cnt_inc[gi]) cnt[gi] <= cnt[gi] + CNT_W'(1);
            end
        end
    endgenerate

    // Every output reads 0 while reset is high, combinational ones included.
    always_comb begin
        stall_f        = 1'b0;
        stall_d        = 1'b0;
        stall_e        = 1'b0;
        stall_m        = 1'b0;
        flush_d        = 1'b0;
        flush_e        = 1'b0;
        flush_w        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        redir_pending  = 1'b0;
        cnt_cycle      = '0;
        cnt_dstall     = '0;
        cnt_lustall    = '0;
        cnt_istall     = '0;
        cnt_branch     = '0;
        if (!reset) begin
            stall_f        = hold_f;
            stall_d        = hold_d;
            stall_e        = d_busy;
            stall_m        = d_busy;
            flush_d        = i_busy & ~hold_d;
            flush_e        = load_use & ~d_busy;
            flush_w        = d_busy;
            redirect_valid = rv_raw;
            redirect_pc    = rpc_raw;
            redir_pending  = (state == PEND);
            cnt_cycle      = cnt[0];
            cnt_dstall     = cnt[1];
            cnt_lustall    = cnt[2];
            cnt_istall     = cnt[3];
            cnt_branch     = cnt[4];
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the controller; a CNT_W=4 copy checks counter wrap.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_busy, d_busy, load_use, branch_taken;
    logic [31:0] branch_target;

    logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
    logic        redirect_valid, redir_pending;
    logic [31:0] redirect_pc;
    logic [31:0] cnt_cycle, cnt_dstall, cnt_lustall, cnt_istall, cnt_branch;

    logic        w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_flush_d, w_flush_e, w_flush_w;
    logic        w_redirect_valid, w_redir_pending;
    logic [31:0] w_redirect_pc;
    logic [3:0]  w_cnt_cycle, w_cnt_dstall, w_cnt_lustall, w_cnt_istall, w_cnt_branch;

    int nvec = 0;
    int nerr = 0;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy), .load_use(load_use),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redir_pending(redir_pending),
        .cnt_cycle(cnt_cycle), .cnt_dstall(cnt_dstall), .cnt_lustall(cnt_lustall),
        .cnt_istall(cnt_istall), .cnt_branch(cnt_branch));

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy), .load_use(load_use),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .stall_f(w_stall_f), .stall_d(w_stall_d), .stall_e(w_stall_e), .stall_m(w_stall_m),
        .flush_d(w_flush_d), .flush_e(w_flush_e), .flush_w(w_flush_w),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc), .redir_pending(w_redir_pending),
        .cnt_cycle(w_cnt_cycle), .cnt_dstall(w_cnt_dstall), .cnt_lustall(w_cnt_lustall),
        .cnt_istall(w_cnt_istall), .cnt_branch(w_cnt_branch));

    always #5 clk = ~clk;

    // Decode must never present a branch while a redirect is parked.
    always @(negedge clk)
        if (!reset) assert (!(redir_pending && branch_taken))
            else $error("branch_taken presented while redirect pending");

    // control bits, MSB first: stall_f stall_d stall_e stall_m flush_d flush_e flush_w redirect_valid redir_pending
    logic [8:0] ctl;
    assign ctl = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w, redirect_valid, redir_pending};

    // ---------------- behavioural model ----------------
    bit          m_pend;
    logic [31:0] m_pc;
    int unsigned m_cycles, m_dst, m_lst, m_ist, m_br;
    logic [8:0]  exp_ctl;
    logic [31:0] exp_pc;

    function automatic bit m_accept();
        return !m_pend && branch_taken && !d_busy && !load_use;
    endfunction

    function automatic void model_eval();
        bit fetch_stuck, dec_stuck, mem_stuck, rv, pend;
        mem_stuck   = d_busy;
        dec_stuck   = mem_stuck || load_use;
        fetch_stuck = dec_stuck || i_busy;
        rv     = m_pend || (m_accept() && !i_busy);
        pend   = m_pend;
        exp_pc = m_pend ? m_pc : (rv ? branch_target : 32'h0);
        exp_ctl = {fetch_stuck, dec_stuck, mem_stuck, mem_stuck,
                   i_busy && !dec_stuck, load_use && !mem_stuck, mem_stuck, rv, pend};
        if (reset) begin
            exp_ctl = '0;
            exp_pc  = '0;
        end
    endfunction

    function automatic void model_step();
        bit fetch_moves;
        if (reset) begin
            m_pend = 0; m_pc = '0;
            m_cycles = 0; m_dst = 0; m_lst = 0; m_ist = 0; m_br = 0;
            return;
        end
        fetch_moves = !(d_busy || load_use || i_busy);
        m_cycles++;
        if (d_busy)        m_dst++;
        else if (load_use) m_lst++;
        else if (i_busy)   m_ist++;
        if (m_accept()) begin
            m_br++;
            if (i_busy) begin m_pend = 1; m_pc = branch_target; end
        end else if (m_pend && fetch_moves) begin
            m_pend = 0;
        end
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic set_in(input bit ib, input bit db, input bit lu, input bit bt, input logic [31:0] tgt);
        i_busy = ib; d_busy = db; load_use = lu; branch_taken = bt; branch_target = tgt;
        #2;
        model_eval();
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 32'h0);
        tick();
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        set_in(1, 1, 1, 1, 32'hDEAD_BEEF);
        nvec++; if (ctl !== 9'b0 || redirect_pc !== 32'h0) begin nerr++;
            $display("FAIL reset_outputs ctl=%b pc=%h want 0", ctl, redirect_pc); end
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if ({cnt_cycle, cnt_dstall, cnt_lustall, cnt_istall, cnt_branch} !== 160'h0) begin nerr++;
            $display("FAIL reset_counters cyc=%0d br=%0d want 0", cnt_cycle, cnt_branch); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(0, 0, 1, 0, 32'h0);
        nvec++; if (ctl !== 9'b110001000) begin nerr++;
            $display("FAIL load_use_cycle ctl=%b want 110001000", ctl); end
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (ctl !== 9'b0) begin nerr++;
            $display("FAIL load_use_after ctl=%b want 0", ctl); end
        nvec++; if (cnt_lustall !== 32'd1 || cnt_dstall !== 32'd0 || cnt_istall !== 32'd0) begin nerr++;
            $display("FAIL load_use_cnt lu=%0d d=%0d i=%0d want 1/0/0", cnt_lustall, cnt_dstall, cnt_istall); end
        tick();
    endtask

    task automatic test_all_stalls();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_in(1, 1, 1, 0, 32'h0);
            nvec++; if (ctl !== 9'b111100100) begin nerr++;
                $display("FAIL all_stalls_c%0d ctl=%b want 111100100", c, ctl); end
            tick();
        end
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (cnt_dstall !== 32'd3 || cnt_lustall !== 32'd0 || cnt_istall !== 32'd0) begin nerr++;
            $display("FAIL all_stalls_cnt d=%0d lu=%0d i=%0d want 3/0/0", cnt_dstall, cnt_lustall, cnt_istall); end
        tick();
    endtask

    task automatic test_branch_ready();
        do_reset();
        set_in(0, 0, 0, 1, 32'hBFC0_0100);
        nvec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC0_0100 || redir_pending !== 1'b0) begin nerr++;
            $display("FAIL branch_ready_redir rv=%b pc=%h pend=%b want 1 bfc00100 0", redirect_valid, redirect_pc, redir_pending); end
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (redirect_valid !== 1'b0 || redir_pending !== 1'b0 || cnt_branch !== 32'd1) begin nerr++;
            $display("FAIL branch_ready_after rv=%b pend=%b br=%0d want 0 0 1", redirect_valid, redir_pending, cnt_branch); end
        tick();
    endtask

    task automatic test_branch_busy();
        do_reset();
        set_in(1, 0, 0, 1, 32'h8000_0040);
        nvec++; if (redirect_valid !== 1'b0 || redir_pending !== 1'b0 || flush_d !== 1'b1) begin nerr++;
            $display("FAIL branch_busy_accept rv=%b pend=%b fd=%b want 0 0 1", redirect_valid, redir_pending, flush_d); end
        tick();
        for (int c = 2; c <= 4; c++) begin
            set_in(1, 0, 0, 0, 32'h0);
            nvec++; if (ctl !== 9'b100010011 || redirect_pc !== 32'h8000_0040) begin nerr++;
                $display("FAIL branch_busy_c%0d ctl=%b pc=%h want 100010011 80000040", c, ctl, redirect_pc); end
            tick();
        end
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (ctl !== 9'b000000011 || redirect_pc !== 32'h8000_0040) begin nerr++;
            $display("FAIL branch_busy_consume ctl=%b pc=%h want 000000011 80000040", ctl, redirect_pc); end
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (ctl !== 9'b0 || cnt_branch !== 32'd1 || cnt_istall !== 32'd4) begin nerr++;
            $display("FAIL branch_busy_idle ctl=%b br=%0d ist=%0d want 0 1 4", ctl, cnt_branch, cnt_istall); end
        tick();
    endtask

    task automatic test_branch_lu();
        do_reset();
        set_in(0, 0, 1, 1, 32'h0000_1234);
        nvec++; if (redirect_valid !== 1'b0 || redir_pending !== 1'b0) begin nerr++;
            $display("FAIL branch_lu_hold rv=%b pend=%b want 0 0", redirect_valid, redir_pending); end
        tick();
        set_in(0, 0, 0, 1, 32'h0000_1234);
        nvec++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1234 || cnt_branch !== 32'd0) begin nerr++;
            $display("FAIL branch_lu_accept rv=%b pc=%h br=%0d want 1 00001234 0", redirect_valid, redirect_pc, cnt_branch); end
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (cnt_branch !== 32'd1) begin nerr++;
            $display("FAIL branch_lu_cnt br=%0d want 1", cnt_branch); end
        tick();
    endtask

    task automatic test_reset_pend();
        do_reset();
        set_in(1, 0, 0, 1, 32'h0BAD_F00D);
        tick();
        set_in(1, 0, 0, 0, 32'h0);
        nvec++; if (redir_pending !== 1'b1) begin nerr++;
            $display("FAIL reset_pend_enter pend=%b want 1", redir_pending); end
        reset = 1'b1;
        set_in(1, 0, 0, 0, 32'h0);
        nvec++; if (ctl !== 9'b0 || redirect_pc !== 32'h0) begin nerr++;
            $display("FAIL reset_pend_gate ctl=%b pc=%h want 0", ctl, redirect_pc); end
        tick();
        reset = 1'b0;
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (redir_pending !== 1'b0 || redirect_valid !== 1'b0 ||
                    {cnt_cycle, cnt_dstall, cnt_lustall, cnt_istall, cnt_branch} !== 160'h0) begin nerr++;
            $display("FAIL reset_pend_after pend=%b rv=%b cyc=%0d br=%0d want 0 0 0 0", redir_pending, redirect_valid, cnt_cycle, cnt_branch); end
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 15; c++) begin set_in(0, 0, 0, 0, 32'h0); tick(); end
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (w_cnt_cycle !== 4'd15) begin nerr++;
            $display("FAIL wrap_top got=%0d want 15", w_cnt_cycle); end
        tick();
        set_in(0, 0, 0, 0, 32'h0);
        nvec++; if (w_cnt_cycle !== 4'd0 || cnt_cycle !== 32'd16) begin nerr++;
            $display("FAIL wrap_zero w=%0d wide=%0d want 0 16", w_cnt_cycle, cnt_cycle); end
        tick();
    endtask

    task automatic test_random();
        bit ib, db, lu, bt;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            ib = ($urandom_range(0, 2) == 0);
            db = ($urandom_range(0, 4) == 0);
            lu = ($urandom_range(0, 4) == 0);
            bt = !m_pend && ($urandom_range(0, 2) == 0);
            set_in(ib, db, lu, bt, $urandom);
            nvec++; if (ctl !== exp_ctl) begin nerr++;
                $display("FAIL rand_ctl n=%0d got=%b want=%b", n, ctl, exp_ctl); end
            nvec++; if (redirect_pc !== exp_pc) begin nerr++;
                $display("FAIL rand_pc n=%0d got=%h want=%h", n, redirect_pc, exp_pc); end
            nvec++; if ({cnt_cycle, cnt_dstall, cnt_lustall, cnt_istall, cnt_branch} !==
                        (reset ? 160'h0 : {m_cycles, m_dst, m_lst, m_ist, m_br})) begin nerr++;
                $display("FAIL rand_cnt n=%0d got=%0d/%0d/%0d/%0d/%0d want=%0d/%0d/%0d/%0d/%0d", n,
                         cnt_cycle, cnt_dstall, cnt_lustall, cnt_istall, cnt_branch,
                         m_cycles, m_dst, m_lst, m_ist, m_br); end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        {i_busy, d_busy, load_use, branch_taken} = '0;
        branch_target = '0;
        m_pend = 0; m_pc = '0;
        m_cycles = 0; m_dst = 0; m_lst = 0; m_ist = 0; m_br = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_all_stalls();
        test_branch_ready();
        test_branch_busy();
        test_branch_lu();
        test_reset_pend();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
